// File: rtl/sa_pe_v2.sv
// Parametrised systolic-array PE: double-buffered weights, WS/OS modes, OS column drain chain.
// Optional macro SA_PE_SAT_EN: saturating WS/OS accumulate instead of modulo-2^ACC_W wrap.
module sa_pe_v2 #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PE_enable,
    input  logic              is_signed,
    input  logic              mode,
    input  logic              load_weight,
    input  logic              weight_swap,
    input  logic              drain,
    input  logic              valid_left,
    input  logic [DATA_W-1:0] input_left,
    input  logic [ACC_W-1:0]  input_top,
    output logic [DATA_W-1:0] out_right,
    output logic              valid_right,
    output logic [ACC_W-1:0]  out_bot
);

    logic [DATA_W-1:0] shadow_w;
    logic [DATA_W-1:0] active_w;
    logic [ACC_W-1:0]  acc;

    logic signed [ACC_W-1:0] ws_prod_p0;
    logic signed [ACC_W-1:0] os_prod_p0;

    // Operands are extended to ACC_W before multiplying; since ACC_W >= 2*DATA_W the
    // truncated result equals the sign/zero-extended 2*DATA_W-bit product.
    function automatic logic signed [ACC_W-1:0] ext_op(input logic [DATA_W-1:0] v,
                                                       input logic sgn);
        return {{(ACC_W-DATA_W){sgn & v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b,
                                                        input logic sgn);
        return ext_op(a, sgn) * ext_op(b, sgn);
    endfunction

`ifdef SA_PE_SAT_EN
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (is_signed) begin
            if ((a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]))
                return a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            return sum[ACC_W-1:0];
        end
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction
`else
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        return a + b;
    endfunction
`endif

    assign ws_prod_p0 = mul_ext(input_left, active_w, is_signed);
    assign os_prod_p0 = mul_ext(input_left, input_top[DATA_W-1:0], is_signed);

    // Single register stage: every output and all PE state update here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_right   <= '0;
            valid_right <= 1'b0;
            out_bot     <= '0;
            shadow_w    <= '0;
            active_w    <= '0;
            acc         <= '0;
        end else if (PE_enable) begin
            out_right   <= input_left;
            valid_right <= valid_left;
            if (weight_swap)
                active_w <= shadow_w;
            if (load_weight) begin
                shadow_w <= input_top[DATA_W-1:0];
                out_bot  <= {{(ACC_W-DATA_W){1'b0}}, shadow_w};
            end else if (!mode) begin
                out_bot <= valid_left ? acc_add(input_top, ws_prod_p0) : input_top;
            end else if (drain) begin
                out_bot <= acc;
                acc     <= input_top;
            end else begin
                out_bot <= input_top;
                if (valid_left)
                    acc <= acc_add(acc, os_prod_p0);
            end
        end
    end

endmodule

// File: tb/tb_sa_pe_v2.sv
// Directed self-checking bench for sa_pe_v2; out_bot expectations flow through a scoreboard queue.
module tb_sa_pe_v2;
    localparam int DATA_W = 4;
    localparam int ACC_W  = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              PE_enable, is_signed, mode, load_weight, weight_swap, drain, valid_left;
    logic [DATA_W-1:0] input_left;
    logic [ACC_W-1:0]  input_top;
    logic [DATA_W-1:0] out_right;
    logic              valid_right;
    logic [ACC_W-1:0]  out_bot;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic [ACC_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    sa_pe_v2 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .PE_enable(PE_enable), .is_signed(is_signed),
        .mode(mode), .load_weight(load_weight), .weight_swap(weight_swap), .drain(drain),
        .valid_left(valid_left), .input_left(input_left), .input_top(input_top),
        .out_right(out_right), .valid_right(valid_right), .out_bot(out_bot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic sg, input logic md, input logic lw,
                          input logic sw, input logic dr, input logic vl,
                          input logic [DATA_W-1:0] left, input logic [ACC_W-1:0] top);
        PE_enable = en; is_signed = sg; mode = md; load_weight = lw;
        weight_swap = sw; drain = dr; valid_left = vl; input_left = left; input_top = top;
    endtask

    // Push the expected out_bot, clock once, then pop and compare after the edge.
    task automatic step(input string tag, input logic [ACC_W-1:0] exp_bot);
        logic [ACC_W-1:0] e;
        exp_q.push_back(exp_bot);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {20'd0, out_bot}, {20'd0, e});
        end
    endtask

    initial begin
        reset = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 4'h0, 12'h000);
        #3;
        chk("rst_out_bot", {20'd0, out_bot}, 32'h0);
        chk("rst_out_right", {28'd0, out_right}, 32'h0);
        chk("rst_valid_right", {31'd0, valid_right}, 32'h0);
        chk("rst_acc", {20'd0, dut.acc}, 32'h0);
        chk("rst_shadow", {28'd0, dut.shadow_w}, 32'h0);
        chk("rst_active", {28'd0, dut.active_w}, 32'h0);
        #9;
        reset = 1'b1;

        // Weight chain
        set_in(1, 0, 0, 1, 0, 0, 0, 4'h0, 12'h005);
        step("load1_bot", 12'h000);
        set_in(1, 0, 0, 1, 0, 0, 0, 4'h0, 12'h00A);
        step("load2_bot", 12'h005);
        chk("load2_shadow", {28'd0, dut.shadow_w}, 32'hA);
        set_in(1, 0, 0, 0, 1, 0, 0, 4'h0, 12'h000);
        step("swap_bot", 12'h000);
        chk("swap_active", {28'd0, dut.active_w}, 32'hA);
        set_in(1, 0, 0, 1, 1, 0, 0, 4'h0, 12'h003);
        step("ldswap_bot", 12'h00A);
        chk("ldswap_active", {28'd0, dut.active_w}, 32'hA);
        chk("ldswap_shadow", {28'd0, dut.shadow_w}, 32'h3);
        set_in(1, 0, 0, 1, 0, 0, 0, 4'h0, 12'h00F);
        step("loadF_bot", 12'h003);
        set_in(1, 0, 0, 0, 1, 0, 0, 4'h0, 12'h000);
        step("swapF_bot", 12'h000);
        chk("swapF_active", {28'd0, dut.active_w}, 32'hF);

        // WS unsigned / signed
        set_in(1, 0, 0, 0, 0, 0, 1, 4'hF, 12'h010);
        step("ws_u_bot", 12'h0F1);
        chk("ws_u_right", {28'd0, out_right}, 32'hF);
        chk("ws_u_vright", {31'd0, valid_right}, 32'h1);
        set_in(1, 0, 0, 0, 0, 0, 0, 4'hF, 12'h010);
        step("ws_pass_bot", 12'h010);
        chk("ws_pass_vright", {31'd0, valid_right}, 32'h0);
        set_in(1, 1, 0, 0, 0, 0, 1, 4'h7, 12'h000);
        step("ws_s_bot", 12'hFF9);

        // Overflow boundaries with active_w = 1
        set_in(1, 1, 0, 1, 0, 0, 0, 4'h0, 12'h001);
        step("load1w_bot", 12'h00F);
        set_in(1, 1, 0, 0, 1, 0, 0, 4'h0, 12'h000);
        step("swap1w_bot", 12'h000);
        set_in(1, 1, 0, 0, 0, 0, 1, 4'h1, 12'h7FF);
`ifdef SA_PE_SAT_EN
        step("ovf_s_pos", 12'h7FF);
`else
        step("ovf_s_pos", 12'h800);
`endif
        set_in(1, 1, 0, 0, 0, 0, 1, 4'hF, 12'h800);
`ifdef SA_PE_SAT_EN
        step("ovf_s_neg", 12'h800);
`else
        step("ovf_s_neg", 12'h7FF);
`endif
        set_in(1, 0, 0, 0, 0, 0, 1, 4'h1, 12'hFFF);
`ifdef SA_PE_SAT_EN
        step("ovf_u", 12'hFFF);
`else
        step("ovf_u", 12'h000);
`endif
        chk("ws_acc_hold", {20'd0, dut.acc}, 32'h0);

        // OS accumulate, idle, drain
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 0, 0, 1, 4'h3, 12'h004);
            step("os_mac_bot", 12'h004);
        end
        chk("os_acc", {20'd0, dut.acc}, 32'h024);
        set_in(1, 0, 1, 0, 0, 0, 0, 4'h3, 12'h004);
        step("os_idle_bot", 12'h004);
        chk("os_idle_acc", {20'd0, dut.acc}, 32'h024);
        set_in(1, 0, 1, 0, 0, 1, 1, 4'h3, 12'h111);
        step("drain_bot", 12'h024);
        chk("drain_acc", {20'd0, dut.acc}, 32'h111);

        // Stall: everything frozen despite active controls
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 1, 1, 1, 0, 1, 4'h5, 12'h222);
            step("stall_bot", 12'h024);
        end
        chk("stall_acc", {20'd0, dut.acc}, 32'h111);
        chk("stall_shadow", {28'd0, dut.shadow_w}, 32'h1);
        chk("stall_active", {28'd0, dut.active_w}, 32'h1);
        chk("stall_right", {28'd0, out_right}, 32'h3);

        // Mode change keeps acc
        set_in(1, 0, 0, 0, 0, 0, 0, 4'h2, 12'h050);
        step("ws_again_bot", 12'h050);
        chk("modechg_acc", {20'd0, dut.acc}, 32'h111);
        set_in(1, 0, 1, 0, 0, 0, 1, 4'h1, 12'h002);
        step("os_again_bot", 12'h002);
        chk("os_again_acc", {20'd0, dut.acc}, 32'h113);

        // Asynchronous reset mid-operation
        #2;
        reset = 1'b0;
        #1;
        chk("arst_bot", {20'd0, out_bot}, 32'h0);
        chk("arst_right", {28'd0, out_right}, 32'h0);
        chk("arst_vright", {31'd0, valid_right}, 32'h0);
        chk("arst_acc", {20'd0, dut.acc}, 32'h0);
        chk("arst_active", {28'd0, dut.active_w}, 32'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_acc", {20'd0, dut.acc}, 32'h0);
        #2;
        reset = 1'b1;
        set_in(1, 0, 0, 1, 0, 0, 0, 4'h0, 12'h009);
        step("post_rst_bot", 12'h000);
        chk("post_rst_shadow", {28'd0, dut.shadow_w}, 32'h9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
